iter_muldiv_unit: RTL
=====================

Name: iter_muldiv_unit

Overview:
Parametrised multi-cycle arithmetic unit with a start/busy handshake. It performs an unsigned shift-add multiply or a restoring divide, selected by a mode input, one bit per clock. It adds a done pulse, a full double-width product, a remainder output and a divide-by-zero flag. It sits behind the project top level as the shared datapath for iterative integer ops.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
mode  input  1  0 = multiply, 1 = divide; latched with start
in_a  input  WIDTH  multiplicand / dividend; latched with start
in_b  input  WIDTH  multiplier / divisor; latched with start
busy  output  1  high while iterating
done  output  1  one-cycle pulse when results become valid
out_lo  output  WIDTH  product low half / quotient
out_hi  output  WIDTH  product high half / remainder
div_by_zero  output  1  set with done when mode=1 and in_b=0

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high, via rst.
- Reset values: state IDLE; busy=0, done=0, out_lo=0, out_hi=0, div_by_zero=0; counter and operand registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches mode, in_a and in_b, clears the counter and enters RUN (busy=1 from that edge).
- Divide-by-zero shortcut: in IDLE, start=1 with mode=1 and in_b=0 goes straight to DONE. It sets out_lo=all ones, out_hi=in_a and div_by_zero=1. Busy stays 0.
- RUN: one iteration per cycle, WIDTH iterations total, so busy is high for exactly WIDTH cycles.
  - Multiply: 2*WIDTH accumulator with LSB-first shift-add; the result is the exact 2*WIDTH product with no truncation.
  - Divide: restoring, MSB-first; quotient in out_lo, remainder in out_hi.
  - On the edge ending iteration WIDTH-1: results go to out_lo/out_hi, div_by_zero=0, state moves to DONE, busy=0.
- DONE: done=1 for exactly one cycle.
  - Next edge goes to IDLE.
  - If start=1 during DONE, the new op is accepted directly (DONE->RUN). Back-to-back throughput is one op per WIDTH+1 cycles.
- Latency: from the start-sampling edge to done high is WIDTH+1 edges (1 edge for the divide-by-zero shortcut).
- Output hold: out_lo, out_hi and div_by_zero change only on entry to DONE. They hold through RUN of the next op.
- start while busy=1 is ignored. Operands and mode changing during RUN have no effect.
- rst asserted mid-operation aborts immediately to the reset values. No done pulse is produced for the aborted op.
- Boundary cases:
  - a=0 or b=0 for multiply still takes the full WIDTH cycles, and the result is 0.
  - Divide with a<b gives q=0, r=a.
  - Divide with b=1 gives q=a, r=0.

Decomposition:
- Package iter_arith_pkg holds:
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE.
  - Mode constants MODE_MUL=0, MODE_DIV=1.
- Single module. No sub-module is needed; the iteration step is inline combinational logic feeding the accumulator registers.

Test Plan:
- WIDTH=8: mul 7*2 -> busy high exactly 8 cycles, done pulse 9 edges after start, out_hi=0, out_lo=14.
- mul 255*255 -> out_hi=254, out_lo=1 (0xFE01). Also sweep a,b in 0..3 -> products match a*b, including all zero cases.
- div 7/2 -> out_lo=3, out_hi=1, div_by_zero=0. div 3/5 -> q=0, r=3. div 6/3 -> q=2, r=0.
- div 5/0 -> done 1 edge after start, busy never high, out_lo=255, out_hi=5, div_by_zero=1. A following div 5/3 -> q=1, r=2, div_by_zero cleared.
- start re-pulsed with new operands at cycle 3 of a running mul 6*3 -> ignored, result 18. Start held high in DONE -> next op starts with no IDLE cycle.
- rst pulsed at cycle 4 of div 200/7 -> all outputs 0 asynchronously, no done pulse. A following mul 5*3 -> 15.

Source files
------------

// File: rtl/iter_muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Imported by the datapath and its testbench.
package iter_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/iter_muldiv_unit_if.sv
// Start/busy/done handshake and operand/result bus of the iterative arithmetic unit.
// master = requester, slave = arithmetic unit.
interface iter_muldiv_unit_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out_lo;
   logic [WIDTH-1:0] out_hi;
   logic             div_by_zero;

   modport master (
      output start, mode, in_a, in_b,
      input  busy, done, out_lo, out_hi, div_by_zero
   );

   modport slave (
      input  start, mode, in_a, in_b,
      output busy, done, out_lo, out_hi, div_by_zero
   );
endinterface

// File: rtl/iter_muldiv_unit.sv
// One-bit-per-clock unsigned shift-add multiplier / restoring divider.
// hi_q/lo_q hold the product accumulator or the remainder/quotient pair while running.
module iter_muldiv_unit
   import iter_arith_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input logic               clk,
   input logic               rst,
   iter_muldiv_unit_if.slave bus
);

   state_t             st;
   logic               mode_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [CNT_W-1:0]   cnt;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   out_lo_q;
   logic [WIDTH-1:0]   out_hi_q;
   logic               dbz_q;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   hi_nx;
   logic [WIDTH-1:0]   lo_nx;

   // One iteration step. Multiply: lo_q shifts the multiplier out LSB-first while the
   // carry-extended sum shifts into hi_q. Divide: lo_q shifts the dividend out MSB-first
   // and collects quotient bits; the borrow (trial MSB) decides whether to restore.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      sum   = '0;
      trial = '0;
      hi_nx = hi_q;
      lo_nx = lo_q;
      if (mode_q == MODE_MUL) begin
         sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
         hi_nx = sum[WIDTH:1];
         lo_nx = {sum[0], lo_q[WIDTH-1:1]};
      end else begin
         trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
         if (trial[WIDTH]) begin
            hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_nx = {lo_q[WIDTH-2:0], 1'b0};
         end else begin
            hi_nx = trial[WIDTH-1:0];
            lo_nx = {lo_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= ST_IDLE;
         mode_q   <= MODE_MUL;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         out_lo_q <= '0;
         out_hi_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         done_q <= 1'b0;
         unique case (st)
            ST_IDLE, ST_DONE: begin
               st <= ST_IDLE;
               if (bus.start) begin
                  if (bus.mode == MODE_DIV && bus.in_b == '0) begin
                     st       <= ST_DONE;
                     done_q   <= 1'b1;
                     out_lo_q <= '1;
                     out_hi_q <= bus.in_a;
                     dbz_q    <= 1'b1;
                  end else begin
                     st     <= ST_RUN;
                     busy_q <= 1'b1;
                     mode_q <= bus.mode;
                     hi_q   <= '0;
                     lo_q   <= bus.in_a;
                     opnd_q <= bus.in_b;
                     cnt    <= '0;
                  end
               end
            end
            ST_RUN: begin
               hi_q <= hi_nx;
               lo_q <= lo_nx;
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  st       <= ST_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  out_lo_q <= lo_nx;
                  out_hi_q <= hi_nx;
                  dbz_q    <= 1'b0;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.out_lo      = out_lo_q;
   assign bus.out_hi      = out_hi_q;
   assign bus.div_by_zero = dbz_q;

endmodule
